// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry layout for the instruction fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_STEP = 4;

  // One buffered fetch: the ROM word and the PC it was read from.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with flush and a combinational head read.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: none internally; the caller's credit rule guarantees no overflow.
//
// Ports: clk/rst (sync, active-low); push + wr_entry write at the tail;
// pop advances the head; flush empties the buffer; head is the oldest entry;
// count is the current occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 wr_entry,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               pop_ok;

  // Never retire from an empty buffer, even if the caller asks.
  assign pop_ok = pop && (count != '0);

  // DEPTH is a power of two, so pointer wraparound is plain overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, drives the ROM, buffers words+PCs.
// Latency: issue-to-visible 2 edges; redirect-to-first-valid 3 edges.
// Backpressure: fetch issue stops once buffered + in-flight fetches reach DEPTH.
//
// Ports: clk/rst (sync, active-low); rom_addr/rom_data to the registered ROM;
// redirect_valid/redirect_pc flush and restart fetch; instr_valid/instr/
// instr_pc/instr_ready is the decoder handshake; count is queue occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [INSTR_W-1:0]     rom_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     instr,
  output logic [ADDR_W-1:0]      instr_pc,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_q;
  logic              req_q;
  logic [CNT_W:0]    committed;
  logic              issue;
  logic              push;
  logic              pop;
  entry_t            wr_entry;
  entry_t            head;

  // Credit check counts the in-flight fetch as already occupying a slot, so
  // the push one edge later always has room. A pop in the same cycle is not
  // credited back; that keeps the check off the instr_ready path.
  assign committed = {1'b0, count} + {{CNT_W{1'b0}}, req_q};
  assign issue     = !redirect_valid && (committed < (CNT_W + 1)'(DEPTH));

  // A redirect kills both the word arriving from the ROM and any consume.
  assign push = req_q && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  assign wr_entry.instr = rom_data;
  assign wr_entry.pc    = pc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= '0;
      pc_q     <= '0;
      req_q    <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~ADDR_W'(3);
      req_q    <= 1'b0;
    end else if (issue) begin
      req_q    <= 1'b1;
      pc_q     <= fetch_pc;
      fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
    end else begin
      req_q    <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (count)
  );

  assign rom_addr    = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed timing checks plus a scoreboard monitor that
// checks every consumed instruction against the sequential-PC reference stream.
module tb_fetch_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic [2:0]         count;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total    = 0;
  int   bad      = 0;
  int   consumed = 0;
  int   c0;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .PC_STEP (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .count          (count)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'h1000_0000 + {24'h0, a};
  endfunction

  // Registered ROM: word for the address sampled at the previous edge.
  always @(posedge clk) rom_data <= mem_word(rom_addr);

  // Reference: after a reset or redirect the consumed stream is strictly
  // sequential from the (word-aligned) start PC, modulo 256.
  task automatic load_stream(input logic [7:0] start);
    sbq.delete();
    for (int k = 0; k < 1200; k++) begin
      exp_t e;
      e.pc    = start + 8'(k * 4);
      e.instr = mem_word(e.pc);
      sbq.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake completes at the next rising edge whenever valid and
  // ready are both high with no reset or redirect pending.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      total++;
      if (count > 3'(DEPTH)) begin
        bad++;
        $display("FAIL count_bound: got %0d limit %0d at %0t", count, DEPTH, $time);
      end
      if (!redirect_valid && instr_valid === 1'b1 && instr_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got pc 0x%0h expected none at %0t", instr_pc, $time);
        end else begin
          mon_e = sbq.pop_front();
          check("instr_pc", {56'h0, instr_pc}, {56'h0, mon_e.pc});
          check("instr", {32'h0, instr}, {32'h0, mon_e.instr});
          consumed++;
        end
      end
    end
  end

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_rom_addr", rom_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_count", count, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);

    // Reset overrides a simultaneous redirect
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    tick();
    check("rst_over_redir_addr", rom_addr, 0);
    check("rst_over_redir_count", count, 0);
    redirect_valid = 1'b0;

    // Release with instr_ready=1: valid two edges after release, then no gaps
    load_stream(8'h00);
    instr_ready = 1'b1;
    rst         = 1'b1;
    tick();
    check("e0_valid", instr_valid, 0);
    check("e0_rom_addr", rom_addr, 4);
    tick();
    check("e1_valid", instr_valid, 1);
    check("e1_instr_pc", instr_pc, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_gap", instr_valid, 1);
    end

    // Mid-stream reset, then backpressure from reset
    rst         = 1'b0;
    instr_ready = 1'b0;
    tick();
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_addr", rom_addr, 0);
    load_stream(8'h00);
    rst = 1'b1;
    repeat (10) tick();
    check("bp_count", count, 4);
    check("bp_rom_addr", rom_addr, 16);
    check("bp_head_pc", instr_pc, 0);
    repeat (3) tick();
    check("bp_count_hold", count, 4);
    check("bp_addr_hold", rom_addr, 16);
    c0 = consumed;
    instr_ready = 1'b1;
    repeat (12) tick();
    check("bp_drain_progress", (consumed - c0) >= 10, 1);

    // Redirect with count=3, a fetch in flight, ready=1: redirect wins
    rst         = 1'b0;
    instr_ready = 1'b0;
    tick();
    load_stream(8'h00);
    rst = 1'b1;
    repeat (4) tick();
    check("pre_redir_count", count, 3);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h41;
    instr_ready    = 1'b1;
    load_stream(8'h40);
    tick();
    redirect_valid = 1'b0;
    check("redir_count", count, 0);
    check("redir_valid", instr_valid, 0);
    check("redir_rom_addr", rom_addr, 8'h40);
    tick();
    check("redir_issue_valid", instr_valid, 0);
    tick();
    check("redir_push_valid", instr_valid, 1);
    check("redir_first_pc", instr_pc, 8'h40);
    repeat (6) tick();

    // Wraparound of the fetch PC
    c0             = consumed;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hF8;
    load_stream(8'hF8);
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    check("wrap_first_pc", instr_pc, 8'hF8);
    repeat (6) tick();
    check("wrap_progress", (consumed - c0) >= 4, 1);

    // Random consumer backpressure
    c0 = consumed;
    for (int i = 0; i < 1000; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("rand_progress", (consumed - c0) >= 300, 1);

    instr_ready = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
